// File: rtl/riscv_defines.sv
// Shared RISC-V definitions: access-size encodings, LSU state type and size helpers.
package riscv_defines;

  localparam logic [1:0] DATA_BYTE      = 2'b00;
  localparam logic [1:0] DATA_HALF_WORD = 2'b01;
  localparam logic [1:0] DATA_WORD      = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

  // Byte-lane mask of an access before it is shifted into place.
  function automatic logic [3:0] size_mask(input logic [1:0] ty);
    case (ty)
      DATA_BYTE:      size_mask = 4'h1;
      DATA_HALF_WORD: size_mask = 4'h3;
      DATA_WORD:      size_mask = 4'hF;
      default:        size_mask = 4'h0;
    endcase
  endfunction

  // Access size in bytes minus one, used to locate the last byte for the bounds check.
  function automatic logic [1:0] size_span(input logic [1:0] ty);
    case (ty)
      DATA_BYTE:      size_span = 2'd0;
      DATA_HALF_WORD: size_span = 2'd1;
      DATA_WORD:      size_span = 2'd3;
      default:        size_span = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store mask/data shift and load merge with size masking and extension.
module lsu_align
  import riscv_defines::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  type_i,
  input  logic [31:0] wdata_i,
  input  logic        sign_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] sh_s;

  assign be_o    = {4'h0, size_mask(type_i)} << off_i;
  assign wdata_o = {32'h0, wdata_i} << {off_i, 3'b000};
  assign sh_s    = 32'(rdata_i >> {off_i, 3'b000});

  // Mask the shifted load word to the access size, then zero- or sign-extend.
  always_comb begin
    rdata_o = 32'h0;
    case (type_i)
      DATA_BYTE:      rdata_o = {{24{sign_i & sh_s[7]}}, sh_s[7:0]};
      DATA_HALF_WORD: rdata_o = {{16{sign_i & sh_s[15]}}, sh_s[15:0]};
      DATA_WORD:      rdata_o = sh_s;
      default:        rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_split.sv
// Registered load/store unit: bounds checking, two-beat split of misaligned accesses,
// load merge and a single completion pulse per request.
module lsu_split
  import riscv_defines::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned MEM_BITS         = 20,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  w_en_i,
  input  logic                  r_en_i,
  input  logic [1:0]            type_i,
  input  logic                  sign_extend_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  done_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  output logic                  dmem_valid_o,
  input  logic                  dmem_ready_i,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [31:0]           dmem_wdata_o,
  output logic [3:0]            dmem_we_o,
  input  logic [31:0]           dmem_rdata_i
);

  lsu_state_t            state_q, state_d;
  logic [1:0]            off_q, off_d, type_q, type_d;
  logic                  store_q, store_d, sign_q, sign_d;
  logic [7:0]            be_q, be_d;
  logic [31:0]           whi_q, whi_d, rlo_q, rlo_d, rhi_q, rhi_d;
  logic                  dmem_valid_q, dmem_valid_d;
  logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [31:0]           dmem_wdata_q, dmem_wdata_d;
  logic [3:0]            dmem_we_q, dmem_we_d;
  logic                  done_q, done_d, err_q, err_d, ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [1:0]            al_off_s, al_type_s;
  logic [31:0]           lo_s, hi_s, al_rdata_s;
  logic [7:0]            al_be_s;
  logic [63:0]           al_wdata_s;
  logic [ADDR_WIDTH:0]   last_s;
  logic                  oob_s, req_err_s, accept_s;

  // In IDLE the aligner sees the incoming request; afterwards it sees the captured one.
  assign al_off_s  = (state_q == IDLE) ? addr_i[1:0] : off_q;
  assign al_type_s = (state_q == IDLE) ? type_i      : type_q;
  assign lo_s      = (state_q == BEAT0) ? dmem_rdata_i : rlo_q;
  assign hi_s      = (state_q == BEAT1) ? dmem_rdata_i : rhi_q;

  lsu_align u_align (
    .off_i   (al_off_s),
    .type_i  (al_type_s),
    .wdata_i (wdata_i),
    .sign_i  (sign_q),
    .rdata_i ({hi_s, lo_s}),
    .be_o    (al_be_s),
    .wdata_o (al_wdata_s),
    .rdata_o (al_rdata_s)
  );

  // Last byte is computed one bit wider so an address wrap also counts as out of bounds.
  assign last_s    = {1'b0, addr_i} + (ADDR_WIDTH+1)'(size_span(type_i));
  assign oob_s     = (|(addr_i >> MEM_BITS)) | (|(last_s >> MEM_BITS));
  assign req_err_s = (type_i == 2'b11) | (w_en_i == r_en_i) | oob_s
                   | ((|al_be_s[7:4]) & !ALLOW_MISALIGNED);
  assign accept_s  = req_valid_i & ready_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    off_d        = off_q;
    type_d       = type_q;
    store_d      = store_q;
    sign_d       = sign_q;
    be_d         = be_q;
    whi_d        = whi_q;
    rlo_d        = rlo_q;
    rhi_d        = rhi_q;
    dmem_valid_d = dmem_valid_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_we_d    = dmem_we_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    rdata_d      = 32'h0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          off_d   = addr_i[1:0];
          type_d  = type_i;
          store_d = w_en_i;
          sign_d  = sign_extend_i;
          be_d    = al_be_s;
          whi_d   = al_wdata_s[63:32];
          if (req_err_s) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d      = BEAT0;
            dmem_valid_d = 1'b1;
            dmem_addr_d  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
            dmem_we_d    = w_en_i ? al_be_s[3:0] : 4'h0;
            dmem_wdata_d = al_wdata_s[31:0];
          end
        end else begin
          state_d = IDLE;
        end
      end
      BEAT0: begin
        if (dmem_ready_i) begin
          rlo_d = dmem_rdata_i;
          if (|be_q[7:4]) begin
            state_d      = BEAT1;
            dmem_addr_d  = dmem_addr_q + ADDR_WIDTH'(3'd4);
            dmem_we_d    = store_q ? be_q[7:4] : 4'h0;
            dmem_wdata_d = whi_q;
          end else begin
            state_d      = RESP;
            dmem_valid_d = 1'b0;
            dmem_addr_d  = '0;
            dmem_we_d    = 4'h0;
            dmem_wdata_d = 32'h0;
            done_d       = 1'b1;
            rdata_d      = store_q ? 32'h0 : al_rdata_s;
          end
        end else begin
          state_d = BEAT0;
        end
      end
      BEAT1: begin
        if (dmem_ready_i) begin
          rhi_d        = dmem_rdata_i;
          state_d      = RESP;
          dmem_valid_d = 1'b0;
          dmem_addr_d  = '0;
          dmem_we_d    = 4'h0;
          dmem_wdata_d = 32'h0;
          done_d       = 1'b1;
          rdata_d      = store_q ? 32'h0 : al_rdata_s;
        end else begin
          state_d = BEAT1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State, request, read-data and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      off_q        <= 2'b00;
      type_q       <= 2'b00;
      store_q      <= 1'b0;
      sign_q       <= 1'b0;
      be_q         <= 8'h00;
      whi_q        <= 32'h0;
      rlo_q        <= 32'h0;
      rhi_q        <= 32'h0;
      dmem_valid_q <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= 32'h0;
      dmem_we_q    <= 4'h0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      type_q       <= type_d;
      store_q      <= store_d;
      sign_q       <= sign_d;
      be_q         <= be_d;
      whi_q        <= whi_d;
      rlo_q        <= rlo_d;
      rhi_q        <= rhi_d;
      dmem_valid_q <= dmem_valid_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_we_q    <= dmem_we_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign dmem_valid_o = dmem_valid_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign dmem_we_o    = dmem_we_q;

endmodule
